// File: rtl/snoop_fifo_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : snoop_fifo_arbiter_if
//  Description : Bundle of the two snoop-source FWFT read ports and the
//                XGMII-TX FIFO write port shared by snoop_fifo_arbiter.
//                Snoop word layout: [63:0] data, [64] start, [65] last,
//                [67:66] lane enables, [71:68] carried unchanged.
//  Modports    : master - arbiter side (drives pops, write port, status)
//                slave  - environment side (drives FIFO heads, full)
//  Revision    : 1.0 - initial release
// ============================================================================
interface snoop_fifo_arbiter_if;
    logic [71:0] src0_dout;
    logic        src0_empty;
    logic        src0_rd_en;
    logic [71:0] src1_dout;
    logic        src1_empty;
    logic        src1_rd_en;
    logic [71:0] din;
    logic        full;
    logic        wr_en;
    logic [1:0]  grant;
    logic        sync_err;

    modport master (
        input  src0_dout, src0_empty, src1_dout, src1_empty, full,
        output src0_rd_en, src1_rd_en, din, wr_en, grant, sync_err
    );

    modport slave (
        output src0_dout, src0_empty, src1_dout, src1_empty, full,
        input  src0_rd_en, src1_rd_en, din, wr_en, grant, sync_err
    );
endinterface
`default_nettype wire

// File: rtl/snoop_fifo_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : snoop_fifo_arbiter
//  Description : Packet-level round-robin arbiter sharing one XGMII-TX FIFO
//                write port between two FWFT snoop sources. Whole packets
//                are moved without interleaving, followed by GAP idle cycles.
//                Heads found without a start bit while idle are popped and
//                dropped with a one-cycle sync_err pulse.
//  Ports       : clk        - core clock, rising edge
//                sys_rst_n  - asynchronous active-low reset
//                bus        - snoop_fifo_arbiter_if.master (source pops,
//                             din/wr_en/full write port, grant, sync_err)
//                pkt_cnt0/1, drop_cnt - statistics, only with the
//                             SNOOP_ARB_STATS_EN macro defined
//  Parameters  : GAP   - idle cycles after each packet (0 = none)
//                PRIO0 - round-robin pointer after reset (0 = source 0)
//  Revision    : 1.0 - initial release
// ============================================================================
module snoop_fifo_arbiter #(
    parameter int unsigned GAP   = 7,
    parameter bit          PRIO0 = 1'b0
) (
    input  wire logic                 clk,
    input  wire logic                 sys_rst_n,
    snoop_fifo_arbiter_if.master      bus
`ifdef SNOOP_ARB_STATS_EN
    ,
    output logic [31:0]               pkt_cnt0,
    output logic [31:0]               pkt_cnt1,
    output logic [15:0]               drop_cnt
`endif
);

    localparam int unsigned         c_cnt_w    = (GAP > 1) ? $clog2(GAP + 1) : 1;
    localparam logic [c_cnt_w-1:0]  c_gap_load = c_cnt_w'(GAP);
    localparam logic [c_cnt_w-1:0]  c_one      = c_cnt_w'(1);
    localparam bit                  c_no_gap   = (GAP == 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t               r_state,    w_state_nxt;
    logic [1:0]           r_grant,    w_grant_nxt;
    logic                 r_rr,       w_rr_nxt;
    logic [c_cnt_w-1:0]   r_gap_cnt,  w_gap_cnt_nxt;
    logic [71:0]          r_din,      w_din_nxt;
    logic                 r_wr_en,    w_wr_en_nxt;
    logic                 r_sync_err, w_sync_err_nxt;

    logic                 w_rd_en0;
    logic                 w_rd_en1;
    logic                 w_req0;
    logic                 w_req1;
    logic                 w_disc0;
    logic                 w_disc1;
    logic                 w_last_pop;
    logic [71:0]          w_sel_dout;
    logic                 w_sel_empty;

    // Owner's head word; r_grant[1] set means source 1 owns the packet.
    assign w_sel_dout  = r_grant[1] ? bus.src1_dout  : bus.src0_dout;
    assign w_sel_empty = r_grant[1] ? bus.src1_empty : bus.src0_empty;

    // Requests and desync discards only matter in IDLE; a discard excludes
    // the request of the same source by construction (start bit clear).
    assign w_req0  = !bus.src0_empty &&  bus.src0_dout[64];
    assign w_req1  = !bus.src1_empty &&  bus.src1_dout[64];
    assign w_disc0 = !bus.src0_empty && !bus.src0_dout[64];
    assign w_disc1 = !bus.src1_empty && !bus.src1_dout[64];

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_rr_nxt       = r_rr;
        w_gap_cnt_nxt  = r_gap_cnt;
        w_din_nxt      = r_din;
        w_wr_en_nxt    = 1'b0;
        w_sync_err_nxt = 1'b0;
        w_rd_en0       = 1'b0;
        w_rd_en1       = 1'b0;
        w_last_pop     = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                w_rd_en0       = w_disc0;
                w_rd_en1       = w_disc1;
                w_sync_err_nxt = w_disc0 || w_disc1;
                // The grant cycle itself never pops; XFER starts next cycle.
                if (w_req0 && (!w_req1 || !r_rr)) begin
                    w_grant_nxt = 2'b01;
                    w_state_nxt = ST_XFER;
                end else if (w_req1) begin
                    w_grant_nxt = 2'b10;
                    w_state_nxt = ST_XFER;
                end
            end

            ST_XFER: begin
                if (!w_sel_empty && !bus.full) begin
                    w_rd_en0    = r_grant[0];
                    w_rd_en1    = r_grant[1];
                    w_din_nxt   = w_sel_dout;
                    w_wr_en_nxt = 1'b1;
                    if (w_sel_dout[65]) begin
                        w_last_pop    = 1'b1;
                        w_rr_nxt      = ~r_grant[1];
                        w_grant_nxt   = 2'b00;
                        w_gap_cnt_nxt = c_gap_load;
                        w_state_nxt   = c_no_gap ? ST_IDLE : ST_GAP;
                    end
                end
            end

            ST_GAP: begin
                w_gap_cnt_nxt = r_gap_cnt - c_one;
                if (r_gap_cnt <= c_one) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= ST_IDLE;
            r_grant    <= 2'b00;
            r_rr       <= PRIO0;
            r_gap_cnt  <= '0;
            r_din      <= '0;
            r_wr_en    <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_rr       <= w_rr_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
            r_din      <= w_din_nxt;
            r_wr_en    <= w_wr_en_nxt;
            r_sync_err <= w_sync_err_nxt;
        end
    end

    // Pops are combinational, so they must be forced low while reset is held
    // or a desync head would be consumed during reset.
    assign bus.src0_rd_en = w_rd_en0 && sys_rst_n;
    assign bus.src1_rd_en = w_rd_en1 && sys_rst_n;
    assign bus.din        = r_din;
    assign bus.wr_en      = r_wr_en;
    assign bus.grant      = r_grant;
    assign bus.sync_err   = r_sync_err;

`ifdef SNOOP_ARB_STATS_EN
    // Counters wrap naturally at their maximum value.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
            drop_cnt <= '0;
        end else begin
            if (w_last_pop && r_grant[0]) begin
                pkt_cnt0 <= pkt_cnt0 + 32'd1;
            end
            if (w_last_pop && r_grant[1]) begin
                pkt_cnt1 <= pkt_cnt1 + 32'd1;
            end
            if (w_sync_err_nxt) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_snoop_fifo_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_snoop_fifo_arbiter
//  Description : Self-checking bench for snoop_fifo_arbiter. Source FIFOs are
//                queues; the expected write stream is derived from the packet
//                contents by the arbitration rules (whole packets, round-robin
//                when both request, leading non-start heads dropped).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_snoop_fifo_arbiter;

    localparam int unsigned TB_GAP   = 3;
    localparam bit          TB_PRIO0 = 1'b0;

    logic clk = 1'b0;
    logic sys_rst_n;

    snoop_fifo_arbiter_if bus ();

`ifdef SNOOP_ARB_STATS_EN
    logic [31:0] pkt_cnt0;
    logic [31:0] pkt_cnt1;
    logic [15:0] drop_cnt;
`endif

    snoop_fifo_arbiter #(
        .GAP   (TB_GAP),
        .PRIO0 (TB_PRIO0)
    ) u_dut (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus.master)
`ifdef SNOOP_ARB_STATS_EN
        ,
        .pkt_cnt0  (pkt_cnt0),
        .pkt_cnt1  (pkt_cnt1),
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Source FIFO contents (head at index 0)
    logic [71:0] q0[$];
    logic [71:0] q1[$];

    // Observed write stream
    logic [71:0] wr_log[$];
    int          wr_src[$];
    int          wr_cyc[$];
    int          sync_cnt;
    int          proto_err;
    int          cyc = 0;

    // Reference model results
    logic [71:0] exp_words[$];
    int          exp_src[$];
    int          exp_drops;
    bit          model_ptr;

    task automatic drive_srcs();
        bus.src0_empty = (q0.size() == 0);
        bus.src0_dout  = (q0.size() != 0) ? q0[0] : 72'h0;
        bus.src1_empty = (q1.size() == 0);
        bus.src1_dout  = (q1.size() != 0) ? q1[0] : 72'h0;
    endtask

    function automatic logic [71:0] rand_word(input bit st, input bit lst);
        logic [71:0] w;
        w[31:0]  = $urandom;
        w[63:32] = $urandom;
        w[64]    = st;
        w[65]    = lst;
        w[71:66] = 6'($urandom_range(0, 63));
        return w;
    endfunction

    function automatic void push_pkt(input int src, input int len);
        for (int i = 0; i < len; i++) begin
            if (src == 0) q0.push_back(rand_word(i == 0, i == len - 1));
            else          q1.push_back(rand_word(i == 0, i == len - 1));
        end
    endfunction

    function automatic void clear_logs();
        wr_log.delete();
        wr_src.delete();
        wr_cyc.delete();
        sync_cnt  = 0;
        proto_err = 0;
    endfunction

    // Reference model: repeatedly drop non-start heads, then move one whole
    // packet from the requesting source (pointer breaks ties, then flips to
    // the other source). Works purely on packet contents, not on timing.
    function automatic void model_compute();
        logic [71:0] m0[$];
        logic [71:0] m1[$];
        logic [71:0] w;
        bit r0, r1, d0, d1, s;
        m0 = q0;
        m1 = q1;
        exp_words.delete();
        exp_src.delete();
        exp_drops = 0;
        for (int it = 0; it < 1000; it++) begin
            r0 = (m0.size() != 0) &&  m0[0][64];
            r1 = (m1.size() != 0) &&  m1[0][64];
            d0 = (m0.size() != 0) && !m0[0][64];
            d1 = (m1.size() != 0) && !m1[0][64];
            if (d0) void'(m0.pop_front());
            if (d1) void'(m1.pop_front());
            if (d0 || d1) exp_drops++;
            if (r0 || r1) begin
                s = (r0 && r1) ? model_ptr : r1;
                if (!s) begin
                    do begin
                        w = m0.pop_front();
                        exp_words.push_back(w);
                        exp_src.push_back(0);
                    end while (!w[65] && m0.size() != 0);
                end else begin
                    do begin
                        w = m1.pop_front();
                        exp_words.push_back(w);
                        exp_src.push_back(1);
                    end while (!w[65] && m1.size() != 0);
                end
                model_ptr = !s;
            end else if (!(d0 || d1)) begin
                break;
            end
        end
    endfunction

    // Bus monitor: pops decided during a cycle are sampled at the falling
    // edge, applied to the source queues after the rising edge, and the
    // write port must then carry exactly the word popped (one-cycle latency).
    always begin : mon
        logic        p0, p1, exp_wr;
        logic [71:0] w0, w1;
        logic [1:0]  g;
        @(negedge clk);
        p0 = sys_rst_n && bus.src0_rd_en;
        p1 = sys_rst_n && bus.src1_rd_en;
        w0 = bus.src0_dout;
        w1 = bus.src1_dout;
        g  = bus.grant;
        if ((p0 || p1) && bus.full && g != 2'b00) proto_err++;
        if (p0 && g == 2'b10) proto_err++;
        if (p1 && g == 2'b01) proto_err++;
        if ((p0 && bus.src0_empty) || (p1 && bus.src1_empty)) proto_err++;
        @(posedge clk);
        #1;
        if (sys_rst_n) begin
            if (p0) void'(q0.pop_front());
            if (p1) void'(q1.pop_front());
            drive_srcs();
            exp_wr = (p0 && g == 2'b01) || (p1 && g == 2'b10);
            if (bus.wr_en !== exp_wr) proto_err++;
            else if (exp_wr && bus.din !== (p0 ? w0 : w1)) proto_err++;
            if (bus.wr_en === 1'b1) begin
                wr_log.push_back(bus.din);
                wr_src.push_back((g == 2'b10) ? 1 : 0);
                wr_cyc.push_back(cyc);
            end
            if (bus.sync_err === 1'b1) sync_cnt++;
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        step();
        sys_rst_n = 1'b0;
        bus.full  = 1'b0;
        q0.delete();
        q1.delete();
        drive_srcs();
        step();
        sys_rst_n = 1'b1;
        model_ptr = TB_PRIO0;
        clear_logs();
    endtask

    task automatic run_until_idle(input int max_cycles, input bit rand_full, output bit timed_out);
        int n = 0;
        timed_out = 1'b0;
        while (!(q0.size() == 0 && q1.size() == 0 && bus.grant == 2'b00 && bus.wr_en == 1'b0)) begin
            step();
            if (rand_full) bus.full = ($urandom_range(0, 3) == 0);
            n++;
            if (n > max_cycles) begin
                timed_out = 1'b1;
                break;
            end
        end
        bus.full = 1'b0;
        repeat (TB_GAP + 4) step();
    endtask

    task automatic wait_writes(input int n, output bit timed_out);
        int k = 0;
        timed_out = 1'b0;
        while (wr_log.size() < n) begin
            step();
            k++;
            if (k > 200) begin
                timed_out = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit to;
        step();
        q0.push_back(rand_word(1'b0, 1'b0));
        drive_srcs();
        step();
        checks++; if (bus.din !== 72'h0) begin failures++; $display("FAIL reset_din: got %h expected 0", bus.din); end
        checks++; if (bus.wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en: got %b expected 0", bus.wr_en); end
        checks++; if (bus.grant !== 2'b00) begin failures++; $display("FAIL reset_grant: got %b expected 00", bus.grant); end
        checks++; if (bus.sync_err !== 1'b0) begin failures++; $display("FAIL reset_sync_err: got %b expected 0", bus.sync_err); end
        checks++; if (bus.src0_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en: got %b expected 0", bus.src0_rd_en); end
        sys_rst_n = 1'b1;
        model_ptr = TB_PRIO0;
        clear_logs();
        model_compute();
        run_until_idle(200, 1'b0, to);
        checks++; if (to) begin failures++; $display("FAIL reset_timeout: got timeout expected idle"); end
        checks++; if (sync_cnt !== exp_drops) begin failures++; $display("FAIL reset_discard: got %0d expected %0d", sync_cnt, exp_drops); end
        checks++; if (wr_log.size() !== 0) begin failures++; $display("FAIL reset_writes: got %0d expected 0", wr_log.size()); end
    endtask

    task automatic test_single_packet();
        bit to;
        int bad = 0;
        apply_reset();
        push_pkt(0, 4);
        drive_srcs();
        model_compute();
        run_until_idle(200, 1'b0, to);
        checks++; if (to) begin failures++; $display("FAIL single_timeout: got timeout expected idle"); end
        checks++; if (wr_log.size() !== 4) begin failures++; $display("FAIL single_count: got %0d expected 4", wr_log.size()); end
        for (int i = 0; i < wr_log.size() && i < exp_words.size(); i++) begin
            if (wr_log[i] !== exp_words[i] || wr_src[i] !== 0) bad++;
            if (i > 0 && wr_cyc[i] - wr_cyc[i-1] != 1) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL single_data: got %0d bad words expected 0", bad); end
        checks++; if (proto_err != 0) begin failures++; $display("FAIL single_protocol: got %0d errors expected 0", proto_err); end
`ifdef SNOOP_ARB_STATS_EN
        checks++; if (pkt_cnt0 !== 32'd1) begin failures++; $display("FAIL single_pkt_cnt0: got %0d expected 1", pkt_cnt0); end
`endif
    endtask

    task automatic test_round_robin();
        bit to;
        int bad = 0, gap_bad = 0;
        apply_reset();
        push_pkt(0, 2); push_pkt(0, 2);
        push_pkt(1, 2); push_pkt(1, 2);
        drive_srcs();
        model_compute();
        run_until_idle(300, 1'b0, to);
        checks++; if (to) begin failures++; $display("FAIL rr_timeout: got timeout expected idle"); end
        checks++; if (wr_log.size() !== exp_words.size()) begin failures++; $display("FAIL rr_count: got %0d expected %0d", wr_log.size(), exp_words.size()); end
        for (int i = 0; i < wr_log.size() && i < exp_words.size(); i++) begin
            if (wr_log[i] !== exp_words[i] || wr_src[i] !== exp_src[i]) bad++;
            if (wr_src[i] !== (i / 2) % 2) bad++;
            // Next packet is already waiting: GAP idle cycles plus the grant cycle.
            if (i > 0 && wr_cyc[i] - wr_cyc[i-1] != (exp_words[i-1][65] ? int'(TB_GAP) + 2 : 1)) gap_bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL rr_order: got %0d bad words expected 0", bad); end
        checks++; if (gap_bad != 0) begin failures++; $display("FAIL rr_spacing: got %0d bad spacings expected 0", gap_bad); end
        checks++; if (proto_err != 0) begin failures++; $display("FAIL rr_protocol: got %0d errors expected 0", proto_err); end
    endtask

    task automatic test_backpressure();
        bit to;
        int bad = 0, n0, stall_pop = 0;
        apply_reset();
        push_pkt(0, 4);
        drive_srcs();
        model_compute();
        wait_writes(1, to);
        checks++; if (to) begin failures++; $display("FAIL bp_start: got timeout expected a write"); end
        bus.full = 1'b1;
        n0 = wr_log.size();
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.src0_rd_en !== 1'b0) stall_pop++;
        end
        checks++; if (wr_log.size() - n0 > 1) begin failures++; $display("FAIL bp_writes_in_stall: got %0d expected at most 1", wr_log.size() - n0); end
        checks++; if (stall_pop != 0) begin failures++; $display("FAIL bp_pop_in_stall: got %0d expected 0", stall_pop); end
        checks++; if (bus.grant !== 2'b01) begin failures++; $display("FAIL bp_owner_held: got %b expected 01", bus.grant); end
        bus.full = 1'b0;
        run_until_idle(200, 1'b0, to);
        checks++; if (wr_log.size() !== 4) begin failures++; $display("FAIL bp_count: got %0d expected 4", wr_log.size()); end
        for (int i = 0; i < wr_log.size() && i < exp_words.size(); i++)
            if (wr_log[i] !== exp_words[i]) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL bp_data: got %0d bad words expected 0", bad); end
        checks++; if (proto_err != 0) begin failures++; $display("FAIL bp_protocol: got %0d errors expected 0", proto_err); end
    endtask

    task automatic test_desync();
        bit to;
        int bad = 0;
        apply_reset();
        q1.push_back(rand_word(1'b0, 1'b0));
        q1.push_back(rand_word(1'b0, 1'b1));
        push_pkt(1, 3);
        drive_srcs();
        model_compute();
        run_until_idle(200, 1'b0, to);
        checks++; if (to) begin failures++; $display("FAIL desync_timeout: got timeout expected idle"); end
        checks++; if (sync_cnt !== exp_drops) begin failures++; $display("FAIL desync_pulses: got %0d expected %0d", sync_cnt, exp_drops); end
        checks++; if (wr_log.size() !== exp_words.size()) begin failures++; $display("FAIL desync_count: got %0d expected %0d", wr_log.size(), exp_words.size()); end
        for (int i = 0; i < wr_log.size() && i < exp_words.size(); i++)
            if (wr_log[i] !== exp_words[i] || wr_src[i] !== 1) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL desync_data: got %0d bad words expected 0", bad); end
`ifdef SNOOP_ARB_STATS_EN
        checks++; if (drop_cnt !== 16'd2) begin failures++; $display("FAIL desync_drop_cnt: got %0d expected 2", drop_cnt); end
        checks++; if (pkt_cnt1 !== 32'd1) begin failures++; $display("FAIL desync_pkt_cnt1: got %0d expected 1", pkt_cnt1); end
`endif
    endtask

    task automatic test_reset_mid_packet();
        bit to;
        int bad = 0;
        apply_reset();
        push_pkt(0, 4);
        drive_srcs();
        wait_writes(2, to);
        checks++; if (to) begin failures++; $display("FAIL midrst_start: got timeout expected 2 writes"); end
        bus.full = 1'b1;
        step();
        checks++; if (bus.grant !== 2'b01) begin failures++; $display("FAIL midrst_owner: got %b expected 01", bus.grant); end
        #1;
        sys_rst_n = 1'b0;
        #1;
        checks++; if (bus.grant !== 2'b00 || bus.wr_en !== 1'b0 || bus.din !== 72'h0 || bus.sync_err !== 1'b0) begin
            failures++; $display("FAIL midrst_async: got grant=%b wr_en=%b din=%h expected all zero", bus.grant, bus.wr_en, bus.din);
        end
        checks++; if (bus.src0_rd_en !== 1'b0) begin failures++; $display("FAIL midrst_rd_en: got %b expected 0", bus.src0_rd_en); end
        bus.full = 1'b0;
        push_pkt(0, 2);
        drive_srcs();
        step();
        sys_rst_n = 1'b1;
        model_ptr = TB_PRIO0;
        clear_logs();
        model_compute();
        run_until_idle(200, 1'b0, to);
        checks++; if (sync_cnt !== 2 || exp_drops !== 2) begin failures++; $display("FAIL midrst_discards: got %0d expected 2", sync_cnt); end
        checks++; if (wr_log.size() !== 2) begin failures++; $display("FAIL midrst_count: got %0d expected 2", wr_log.size()); end
        for (int i = 0; i < wr_log.size() && i < exp_words.size(); i++)
            if (wr_log[i] !== exp_words[i]) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL midrst_data: got %0d bad words expected 0", bad); end
    endtask

    task automatic test_single_word();
        bit to;
        int bad = 0;
        apply_reset();
        push_pkt(0, 1);
        push_pkt(1, 3);
        drive_srcs();
        model_compute();
        run_until_idle(200, 1'b0, to);
        checks++; if (wr_log.size() !== 4) begin failures++; $display("FAIL sword_count: got %0d expected 4", wr_log.size()); end
        for (int i = 0; i < wr_log.size() && i < exp_words.size(); i++)
            if (wr_log[i] !== exp_words[i] || wr_src[i] !== exp_src[i]) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL sword_data: got %0d bad words expected 0", bad); end
        if (wr_cyc.size() >= 2) begin
            checks++; if (wr_cyc[1] - wr_cyc[0] != int'(TB_GAP) + 2) begin
                failures++; $display("FAIL sword_gap: got %0d cycles expected %0d", wr_cyc[1] - wr_cyc[0], TB_GAP + 2);
            end
        end
        checks++; if (proto_err != 0) begin failures++; $display("FAIL sword_protocol: got %0d errors expected 0", proto_err); end
    endtask

    task automatic test_random();
        bit to;
        int bad, np;
        apply_reset();
        for (int r = 0; r < 8; r++) begin
            bad = 0;
            clear_logs();
            for (int s = 0; s < 2; s++) begin
                if ($urandom_range(0, 3) == 0) begin
                    if (s == 0) q0.push_back(rand_word(1'b0, $urandom_range(0, 1) == 1));
                    else        q1.push_back(rand_word(1'b0, $urandom_range(0, 1) == 1));
                end
                np = $urandom_range(0, 3);
                for (int p = 0; p < np; p++) push_pkt(s, $urandom_range(1, 5));
            end
            drive_srcs();
            model_compute();
            run_until_idle(2000, 1'b1, to);
            checks++; if (to) begin failures++; $display("FAIL rand_timeout: round %0d got timeout expected idle", r); end
            checks++; if (wr_log.size() !== exp_words.size()) begin failures++; $display("FAIL rand_count: round %0d got %0d expected %0d", r, wr_log.size(), exp_words.size()); end
            for (int i = 0; i < wr_log.size() && i < exp_words.size(); i++)
                if (wr_log[i] !== exp_words[i] || wr_src[i] !== exp_src[i]) bad++;
            checks++; if (bad != 0 || sync_cnt !== exp_drops || proto_err != 0) begin
                failures++; $display("FAIL rand_stream: round %0d bad=%0d sync=%0d expected sync=%0d proto=%0d", r, bad, sync_cnt, exp_drops, proto_err);
            end
        end
    endtask

    initial begin
        sys_rst_n = 1'b0;
        bus.full  = 1'b0;
        drive_srcs();
        test_reset();
        test_single_packet();
        test_round_robin();
        test_backpressure();
        test_desync();
        test_reset_mid_packet();
        test_single_word();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
